// File: rtl/word_load_assembler.sv
// word_load_assembler
//   Packs four bytes from a valid/ready byte source into one 32-bit word,
//   little-endian, and presents it to a load-enabled register as Din plus a
//   one-cycle ld strobe.
//
//   Handshake: a byte transfers on a rising edge where byte_valid and
//   byte_ready are both 1, and on no other edge. The source must hold
//   byte_in/byte_valid until the transfer happens. byte_ready is 1 in COLLECT
//   and 0 in LOAD.
//
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high reset
//     byte_in      byte data from the upstream source
//     byte_valid   byte_in holds a valid byte
//     byte_ready   a byte is accepted this cycle if byte_valid is 1
//     ld           one-cycle load strobe (high exactly in the LOAD state)
//     Din          last complete word; changes only on entry to LOAD
//     busy         partial word held, or LOAD in progress
//     timeout_err  one-cycle pulse when a partial word is discarded
//     dbg_state    FSM state (0 = COLLECT, 1 = LOAD)
//     dbg_cnt      number of bytes of the current word already held
//
//   Build option: define ASM_TIMEOUT_EN to discard a partial word after
//   TIMEOUT_CYCLES idle cycles (legal range 2..255). Without it a partial word
//   is held indefinitely and timeout_err is tied to 0.
module word_load_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        ld,
  output logic [31:0] Din,
  output logic        busy,
  output logic        timeout_err,
  output logic        dbg_state,
  output logic [1:0]  dbg_cnt
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("word_load_assembler: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    LOAD    = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] asm_buf, asm_buf_nxt;
  logic [31:0] din_nxt;
  logic        accept;
  logic        timeout_fire;

  assign accept = byte_valid && byte_ready;

`ifdef ASM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] idle_cnt;
  logic       idle;

  // Idle means a partial word is waiting and nothing arrived this cycle.
  // The counter holds the number of idle cycles already elapsed, so the
  // edge closing idle cycle TIMEOUT_CYCLES is the one that discards.
  assign idle         = (state == COLLECT) && (cnt != 2'd0) && !accept;
  assign timeout_fire = idle && (idle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset || !idle || timeout_fire) begin
      idle_cnt <= 8'd0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_fire;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    asm_buf_nxt = asm_buf;
    din_nxt     = Din;
    case (state)
      COLLECT: begin
        if (accept) begin
          asm_buf_nxt[{cnt, 3'b000} +: 8] = byte_in;
          if (cnt == 2'd3) begin
            // Final byte goes straight to Din alongside the three held bytes.
            din_nxt   = {byte_in, asm_buf[23:0]};
            cnt_nxt   = 2'd0;
            state_nxt = LOAD;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end else if (timeout_fire) begin
          cnt_nxt     = 2'd0;
          asm_buf_nxt = 32'h0;
        end
      end
      LOAD: begin
        state_nxt = COLLECT;
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COLLECT;
      cnt     <= 2'd0;
      asm_buf <= 32'h0;
      Din     <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      asm_buf <= asm_buf_nxt;
      Din     <= din_nxt;
    end
  end

  // ld is the LOAD state itself: high for the single cycle after the edge
  // that accepted the last byte, never on two cycles in a row.
  assign ld         = (state == LOAD);
  assign byte_ready = (state == COLLECT);
  assign busy       = (cnt != 2'd0) || (state == LOAD);
  assign dbg_state  = state;
  assign dbg_cnt    = cnt;

endmodule

// File: tb/tb_word_load_assembler.sv
// tb_word_load_assembler
//   Directed bench for word_load_assembler. Every ld pulse is checked against
//   a queue of hand-computed expected words; other outputs are checked inline
//   one time unit after the clock edge.
module tb_word_load_assembler;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        ld;
  logic [31:0] Din;
  logic        busy;
  logic        timeout_err;
  logic        dbg_state;
  logic [1:0]  dbg_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ld_cyc = -1;
  int ld_gap = 0;
  int ld_count = 0;
  int te_count = 0;
  logic prev_ld = 1'b0;
  logic [31:0] exp_q[$];

  word_load_assembler #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .ld          (ld),
    .Din         (Din),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state),
    .dbg_cnt     (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every ld must match the oldest expected word
  always @(negedge clk) begin
    if (timeout_err === 1'b1) te_count++;
    if (ld === 1'b1) begin
      ld_count++;
      if (last_ld_cyc >= 0) ld_gap = cyc - last_ld_cyc;
      last_ld_cyc = cyc;
      if (prev_ld) check_eq("ld_back_to_back", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ld", Din, 32'hxxxx_xxxx);
      end else begin
        check_eq("ld_din", Din, exp_q.pop_front());
      end
    end
    prev_ld = ld;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic       rdy;
    int         idx;
    int         ld_before;
    logic [31:0] din_hold;

    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    step();
    step();
    reset = 1'b0;

    // reset state
    check_eq("rst_ready", byte_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ld", ld, 0);
    check_eq("rst_din", Din, 32'h0);
    check_eq("rst_terr", timeout_err, 0);

    // four back-to-back bytes, ld in the very next cycle
    exp_q.push_back(32'h44332211);
    byte_valid = 1'b1;
    byte_in = 8'h11; step();
    check_eq("busy_partial", busy, 1);
    byte_in = 8'h22; step();
    byte_in = 8'h33; step();
    byte_in = 8'h44; step();
    byte_valid = 1'b0;
    check_eq("ld_immediate", ld, 1);
    check_eq("din_word0", Din, 32'h44332211);
    check_eq("ready_in_load", byte_ready, 0);
    step();
    check_eq("ld_one_cycle", ld, 0);
    check_eq("busy_after", busy, 0);

    // full-rate stream 01..0A, byte held through LOAD
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    idx = 1;
    while (idx <= 10) begin
      byte_in    = 8'(idx);
      byte_valid = 1'b1;
      rdy        = byte_ready;
      step();
      if (rdy) idx++;
    end
    byte_valid = 1'b0;
    check_eq("stream_gap", ld_gap, 5);
    check_eq("stream_din", Din, 32'h08070605);
    check_eq("stream_cnt", dbg_cnt, 2);
    check_eq("stream_busy", busy, 1);

    // reset drops the partial word (cnt=2) with no ld
    do_reset();
    check_eq("rst_drop_cnt", dbg_cnt, 0);
    check_eq("rst_drop_busy", busy, 0);
    check_eq("rst_drop_din", Din, 32'h0);

    // reset coinciding with the 4th byte wins: no ld
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    ld_before  = ld_count;
    byte_in    = 8'h04;
    byte_valid = 1'b1;
    reset      = 1'b1;
    step();
    reset      = 1'b0;
    byte_valid = 1'b0;
    check_eq("rst_win_state", dbg_state, 0);
    check_eq("rst_win_busy", busy, 0);
    step();
    check_eq("rst_win_no_ld", ld_count, ld_before);

    // AA,BB then reset then a fresh word
    exp_q.push_back(32'h44332211);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_eq("pre_final_din", Din, 32'h0);
    send_byte(8'h44);
    check_eq("after_rst_ld", ld, 1);
    check_eq("after_rst_din", Din, 32'h44332211);
    step();

    // gaps between bytes: valid 1,0,0,1,...
    exp_q.push_back(32'h8D7C6B5A);
    din_hold = 32'h44332211;
    send_byte(8'h5A); idle(2);
    check_eq("gap_din0", Din, din_hold);
    send_byte(8'h6B); idle(2);
    check_eq("gap_din1", Din, din_hold);
    check_eq("gap_cnt", dbg_cnt, 2);
    send_byte(8'h7C); idle(2);
    check_eq("gap_ld", ld, 0);
    send_byte(8'h8D);
    check_eq("gap_final_ld", ld, 1);
    check_eq("gap_final_din", Din, 32'h8D7C6B5A);
    step();

`ifdef ASM_TIMEOUT_EN
    // TIMEOUT_CYCLES=4: one byte, then idle
    ld_before = ld_count;
    send_byte(8'hC3);
    idle(3);
    check_eq("to_early", timeout_err, 0);
    check_eq("to_early_cnt", dbg_cnt, 1);
    idle(1);
    check_eq("to_pulse", timeout_err, 1);
    check_eq("to_cnt", dbg_cnt, 0);
    check_eq("to_busy", busy, 0);
    check_eq("to_din", Din, 32'h8D7C6B5A);
    idle(1);
    check_eq("to_one_cycle", timeout_err, 0);
    check_eq("to_no_ld", ld_count, ld_before);
`else
    // partial word survives a long idle
    exp_q.push_back(32'hDDCCBBAA);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(100);
    check_eq("hold_cnt", dbg_cnt, 3);
    check_eq("hold_busy", busy, 1);
    send_byte(8'hDD);
    check_eq("hold_ld", ld, 1);
    check_eq("hold_din", Din, 32'hDDCCBBAA);
    step();
    check_eq("no_terr", te_count, 0);
`endif

    idle(3);
    check_eq("pending_words", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
